jtag_tap_param: RTL
===================

Name: jtag_tap_param

Overview:
- Parametrised IEEE 1149.1 TAP block. Full 16-state TAP FSM, instruction register of width IR_W, IDCODE register, bypass register and TDO selection in one block.
- Generates the DR control strobes for an external boundary-scan register chain and takes that chain's serial output back in.
- Adds three things the previous TAP/IR/bypass arrangement lacked: configurable IR width and opcodes, an IDCODE data register, and unknown-opcode fallback to BYPASS.

Parameters:
- IR_W, 4, instruction register width (>=2).
- IDCODE_VAL, 32'h1234_5679, device ID; bit0 must be 1.
- OP_EXTEST, 0, EXTEST opcode.
- OP_SAMPLE, 1, SAMPLE/PRELOAD opcode.
- OP_IDCODE, 2, IDCODE opcode.
- BYPASS opcode is all-ones (fixed, not a parameter).

Ports:
- TCLK  in  1  test clock; all state updates on the rising edge.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- bsr_tdo  in  1  serial output of the external BSR chain.
- TDO  out  1  serial data out.
- tdo_en  out  1  high in Shift-IR / Shift-DR only.
- tap_state  out  4  current FSM state.
- capture_dr  out  1  state == Capture-DR.
- shift_dr  out  1  state == Shift-DR.
- update_dr  out  1  state == Update-DR.
- bsr_sel  out  1  active instruction is EXTEST or SAMPLE.
- bs_mode  out  1  active instruction is EXTEST (BSR drives pins).
- ir_active  out  IR_W  currently latched instruction.

Behaviour:
- One clock (TCLK); reset is asynchronous and active-high (TRST). No other clock.
- TRST asserted, at any time including mid-shift:
  - tap_state = Test-Logic-Reset.
  - ir_active = OP_IDCODE; IR shift reg = 0.
  - IDCODE shift reg = IDCODE_VAL; bypass = 0.
  - All strobes = 0; tdo_en = 0; TDO = 0.
- FSM: the standard 16 states and TMS transitions, encoding fixed in the package:
  - TLR -TMS0-> RTI; RTI -1-> SelDR.
  - SelDR -0-> CapDR, -1-> SelIR; SelIR -0-> CapIR, -1-> TLR.
  - Cap -0-> Shift, -1-> Exit1; Shift -1-> Exit1.
  - Exit1 -0-> Pause, -1-> Update; Pause -1-> Exit2.
  - Exit2 -0-> Shift, -1-> Update; Update -0-> RTI, -1-> SelDR.
- Any state reaches TLR within 5 consecutive TMS=1 clocks. Entering TLR synchronously forces ir_active = OP_IDCODE.
- Strobes are combinational decodes of registered state; the action happens on the edge that leaves that state.
- IR path:
  - In Capture-IR the IR shift reg loads {0..0,1,0}? No: it loads 'b0...01, i.e. LSB=1, others 0.
  - In Shift-IR, shift right each clock: MSB <= TDI, TDO = LSB.
  - In Update-IR, ir_active <= shift reg.
  - Opcode not in {EXTEST, SAMPLE, IDCODE} is treated as BYPASS for DR selection.
- DR selection by ir_active:
  - IDCODE: 32-bit shift reg, loaded with IDCODE_VAL in Capture-DR; in Shift-DR MSB <= TDI, TDO = LSB.
  - BYPASS/unknown: 1-bit reg, loaded 0 in Capture-DR, <= TDI in Shift-DR; TDO = bypass bit, giving a 1-clock delay.
  - EXTEST/SAMPLE: TDO = bsr_tdo; the strobes drive the external BSR.
- TDO: combinational; IR LSB in Shift-IR, selected DR output in Shift-DR, 0 otherwise.
- Pause-DR/Pause-IR hold all shift registers unchanged.
- Capture with no following shift (Exit1 -> Update) still commits the captured IR value.

Decomposition:
- Package jtag_pkg holds:
  - the tap_state_t enum (TLR=0, RTI, SelDR, CapDR, ShDR, Ex1DR, PsDR, Ex2DR, UpDR, SelIR, CapIR, ShIR, Ex1IR, PsIR, Ex2IR, UpIR=15);
  - a next-state function;
  - the default opcode constants.
- Sub-module jtag_tap_fsm: the state register plus next-state logic and strobe decode. The top level holds the IR, IDCODE, bypass and TDO mux.

Test Plan:
1. Pulse TRST mid-Shift-DR -> tap_state=0, ir_active=2, TDO=0, tdo_en=0 immediately; no clock needed.
2. From TLR, TMS 0,1,0,0, then 32 clocks in Shift-DR (TMS=1 on the last) -> TDO bit sequence LSB-first = 0x12345679; tdo_en high for exactly 32 clocks.
3. Load IR=4'hF through Capture/Shift/Update-IR -> during capture-shift, TDO shows 1,0,0,0. Then shift DR pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-clock delay).
4. Load IR=4'h0 -> bs_mode=1, bsr_sel=1. In Shift-DR, TDO follows bsr_tdo. capture_dr/update_dr pulse for one clock each.
5. Load an unknown opcode 4'h7 -> DR behaves as bypass; bsr_sel=0.
6. From each of the 16 states, apply 5 clocks of TMS=1 -> tap_state=TLR and ir_active=OP_IDCODE.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, DR selector, default opcodes, next-state function.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a; the JTAG protocol has no flow control.
package jtag_pkg;

    // Standard IEEE 1149.1 TAP states; the encoding is visible on tap_state.
    typedef enum logic [3:0] {
        TLR   = 4'd0,
        RTI   = 4'd1,
        SELDR = 4'd2,
        CAPDR = 4'd3,
        SHDR  = 4'd4,
        EX1DR = 4'd5,
        PSDR  = 4'd6,
        EX2DR = 4'd7,
        UPDR  = 4'd8,
        SELIR = 4'd9,
        CAPIR = 4'd10,
        SHIR  = 4'd11,
        EX1IR = 4'd12,
        PSIR  = 4'd13,
        EX2IR = 4'd14,
        UPIR  = 4'd15
    } tap_state_t;

    // Which data register sits between TDI and TDO in Shift-DR.
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_BSR    = 2'd2
    } dr_sel_t;

    localparam int unsigned OP_EXTEST_DEF = 0;
    localparam int unsigned OP_SAMPLE_DEF = 1;
    localparam int unsigned OP_IDCODE_DEF = 2;

    // TMS-driven transition table of the TAP controller.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TLR;
        case (s)
            TLR:   n = tms ? TLR   : RTI;
            RTI:   n = tms ? SELDR : RTI;
            SELDR: n = tms ? SELIR : CAPDR;
            CAPDR: n = tms ? EX1DR : SHDR;
            SHDR:  n = tms ? EX1DR : SHDR;
            EX1DR: n = tms ? UPDR  : PSDR;
            PSDR:  n = tms ? EX2DR : PSDR;
            EX2DR: n = tms ? UPDR  : SHDR;
            UPDR:  n = tms ? SELDR : RTI;
            SELIR: n = tms ? TLR   : CAPIR;
            CAPIR: n = tms ? EX1IR : SHIR;
            SHIR:  n = tms ? EX1IR : SHIR;
            EX1IR: n = tms ? UPIR  : PSIR;
            PSIR:  n = tms ? EX2IR : PSIR;
            EX2IR: n = tms ? UPIR  : SHIR;
            UPIR:  n = tms ? SELDR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller: 16-state register, next-state logic and per-state strobe decode.
// Latency: strobes are combinational decodes of the registered state (0 cycles from state).
// Backpressure: none; advances on every TCLK rising edge according to TMS.
// Ports: TCLK/TRST clock and async active-high reset; TMS mode select;
//        state/state_next current and upcoming state; *_dr/*_ir state strobes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state,
    output tap_state_t state_next,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = tap_next(state, TMS);
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        case (state)
            CAPDR:   capture_dr = 1'b1;
            SHDR:    shift_dr   = 1'b1;
            UPDR:    update_dr  = 1'b1;
            CAPIR:   capture_ir = 1'b1;
            SHIR:    shift_ir   = 1'b1;
            UPIR:    update_ir  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: FSM, IR, IDCODE and bypass registers, TDO mux, BSR strobes.
// Latency: TDO is combinational from registered state; bypass path adds one TCLK of delay.
// Backpressure: none; all state moves on TCLK rising edges, TRST resets asynchronously.
// Ports: TCLK/TRST/TMS/TDI JTAG inputs; bsr_tdo external chain return; TDO/tdo_en serial out;
//        tap_state current state; capture/shift/update_dr BSR strobes; bsr_sel/bs_mode
//        instruction decodes; ir_active latched instruction.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
    parameter int unsigned OP_EXTEST  = OP_EXTEST_DEF,
    parameter int unsigned OP_SAMPLE  = OP_SAMPLE_DEF,
    parameter int unsigned OP_IDCODE  = OP_IDCODE_DEF
) (
    input  logic            TCLK,
    input  logic            TRST,
    input  logic            TMS,
    input  logic            TDI,
    input  logic            bsr_tdo,
    output logic            TDO,
    output logic            tdo_en,
    output logic [3:0]      tap_state,
    output logic            capture_dr,
    output logic            shift_dr,
    output logic            update_dr,
    output logic            bsr_sel,
    output logic            bs_mode,
    output logic [IR_W-1:0] ir_active
);

    localparam logic [IR_W-1:0] OPC_EXTEST = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] OPC_SAMPLE = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] OPC_IDCODE = IR_W'(OP_IDCODE);
    // Capture-IR pattern: LSB=1, rest 0, so a broken chain is visible on the first bits out.
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    tap_state_t      state;
    tap_state_t      state_next;
    logic            capture_ir;
    logic            shift_ir;
    logic            update_ir;
    logic [IR_W-1:0] ir_shift;
    logic [31:0]     id_shift;
    logic            bypass_bit;
    dr_sel_t         dr_sel;
    logic            dr_out;

    jtag_tap_fsm u_fsm (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .state_next (state_next),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    assign tap_state = state;

    // Anything not explicitly recognised falls back to the bypass register.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_active == OPC_EXTEST || ir_active == OPC_SAMPLE) begin
            dr_sel = DR_BSR;
        end else if (ir_active == OPC_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
    end

    assign bsr_sel = (dr_sel == DR_BSR);
    assign bs_mode = (ir_active == OPC_EXTEST);

    // Instruction register. ir_active is forced on the edge that enters TLR so that a
    // 5x TMS=1 sequence leaves IDCODE selected without needing an extra clock in TLR.
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            ir_shift  <= '0;
            ir_active <= OPC_IDCODE;
        end else begin
            if (capture_ir) begin
                ir_shift <= IR_CAPTURE;
            end else if (shift_ir) begin
                ir_shift <= {TDI, ir_shift[IR_W-1:1]};
            end

            if (state_next == TLR) begin
                ir_active <= OPC_IDCODE;
            end else if (update_ir) begin
                ir_active <= ir_shift;
            end
        end
    end

    // IDCODE and bypass data registers; each only moves while it is the selected DR,
    // and both hold through Pause-DR because no strobe is active there.
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            id_shift   <= IDCODE_VAL;
            bypass_bit <= 1'b0;
        end else begin
            if (dr_sel == DR_IDCODE) begin
                if (capture_dr) begin
                    id_shift <= IDCODE_VAL;
                end else if (shift_dr) begin
                    id_shift <= {TDI, id_shift[31:1]};
                end
            end
            if (dr_sel == DR_BYPASS) begin
                if (capture_dr) begin
                    bypass_bit <= 1'b0;
                end else if (shift_dr) begin
                    bypass_bit <= TDI;
                end
            end
        end
    end

    always_comb begin
        dr_out = bypass_bit;
        case (dr_sel)
            DR_IDCODE: dr_out = id_shift[0];
            DR_BSR:    dr_out = bsr_tdo;
            default:   dr_out = bypass_bit;
        endcase
    end

    always_comb begin
        TDO    = 1'b0;
        tdo_en = shift_ir | shift_dr;
        if (shift_ir) begin
            TDO = ir_shift[0];
        end else if (shift_dr) begin
            TDO = dr_out;
        end
    end

endmodule
